imem_stream_loader: RTL

- Synthesizable successor to the bench-only instruction-memory backdoor fill for the mips_16 core.
- Accepts a valid/ready word stream, writes it sequentially into the instruction ROM write port, and optionally pads unused locations with a NOP word.
- Keeps the core held in reset until the image is complete, and reports the word count and a running checksum.
- Sits between the program source (bench driver or boot UART) and the IF-stage instruction memory.

---
 rtl/MIPS_pkg.sv | 23 ++
 rtl/imem_stream_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/MIPS_pkg.sv
// Shared types and constants for the mips_16 instruction-memory loader.
// The state enum is exported so benches and checkers can decode the
// loader's debug state output without duplicating the encoding.
package MIPS_pkg;

   // mips_16 instruction word width and instruction memory depth
   localparam int INSTR_W    = 16;
   localparam int IMEM_DEPTH = 256;

   // Default pad word written to unused instruction memory locations
   localparam logic [INSTR_W-1:0] MIPS_NOP = 16'h0000;

   // Loader sequencing states
   typedef enum logic [2:0] {
      LS_IDLE  = 3'd0,
      LS_LOAD  = 3'd1,
      LS_FILL  = 3'd2,
      LS_DRAIN = 3'd3,
      LS_DONE  = 3'd4,
      LS_ERR   = 3'd5
   } loader_state_e;

endpackage

// File: rtl/imem_stream_loader.sv
// Streams a program image into the instruction memory write port.
// Words arrive on a valid/ready stream and are written to consecutive
// addresses starting at 0; optionally the remainder of the memory is
// padded with NOP_WORD. The core is held in reset until the image is
// complete. An image longer than the memory is swallowed to its last
// word and then flagged as an error.
//
// Handshake: a stream word is transferred on a rising clock edge where
// in_valid and in_ready are both high. in_ready depends only on the
// loader state (never on in_valid), and a source seeing in_ready low
// holds in_valid, in_data and in_last stable until the transfer.
module imem_stream_loader
   import MIPS_pkg::*;
#(
   parameter int                 DATA_W   = INSTR_W,
   parameter int                 DEPTH    = IMEM_DEPTH,
   parameter int                 FILL_EN  = 1,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(MIPS_NOP),
   localparam int                ADDR_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                core_hold,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     word_count,
   output logic [DATA_W-1:0]   checksum,
   output loader_state_e       dbg_state
);

   loader_state_e        state;
   loader_state_e        state_nxt;
   logic [ADDR_W-1:0]    pad_addr;
   logic [ADDR_W-1:0]    pad_addr_nxt;
   logic                 mem_we_nxt;
   logic [ADDR_W-1:0]    mem_addr_nxt;
   logic [DATA_W-1:0]    mem_wdata_nxt;
   logic                 core_hold_nxt;
   logic                 done_nxt;
   logic                 err_nxt;
   logic [ADDR_W:0]      word_count_nxt;
   logic [DATA_W-1:0]    checksum_nxt;
   logic                 accept;

   // Stream acceptance: ready only while taking (LOAD) or discarding (DRAIN) words
   always_comb begin
      in_ready = (state == LS_LOAD) || (state == LS_DRAIN);
      accept   = in_valid && in_ready;
   end

   // Next-state and next-output decode; every write is registered so it
   // appears on the memory port one cycle after the word is accepted
   always_comb begin
      state_nxt      = state;
      pad_addr_nxt   = pad_addr;
      mem_we_nxt     = 1'b0;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      core_hold_nxt  = core_hold;
      done_nxt       = done;
      err_nxt        = err;
      word_count_nxt = word_count;
      checksum_nxt   = checksum;

      case (state)
         LS_IDLE: begin
            word_count_nxt = '0;
            checksum_nxt   = '0;
            done_nxt       = 1'b0;
            err_nxt        = 1'b0;
            core_hold_nxt  = 1'b1;
            if (start) begin
               state_nxt = LS_LOAD;
            end
         end

         LS_LOAD: begin
            if (accept) begin
               mem_we_nxt     = 1'b1;
               mem_addr_nxt   = word_count[ADDR_W-1:0];
               mem_wdata_nxt  = in_data;
               word_count_nxt = word_count + (ADDR_W+1)'(1);
               checksum_nxt   = checksum + in_data;
               if (in_last) begin
                  if ((FILL_EN != 0) && (int'(word_count) + 1 < DEPTH)) begin
                     state_nxt    = LS_FILL;
                     pad_addr_nxt = word_count[ADDR_W-1:0] + ADDR_W'(1);
                  end else begin
                     state_nxt     = LS_DONE;
                     done_nxt      = 1'b1;
                     core_hold_nxt = 1'b0;
                  end
               end else if (int'(word_count) == DEPTH - 1) begin
                  // Memory is now full; anything else the source sends is surplus
                  state_nxt = LS_DRAIN;
               end
            end
         end

         LS_FILL: begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = pad_addr;
            mem_wdata_nxt = NOP_WORD;
            if (int'(pad_addr) == DEPTH - 1) begin
               state_nxt     = LS_DONE;
               done_nxt      = 1'b1;
               core_hold_nxt = 1'b0;
            end else begin
               pad_addr_nxt = pad_addr + ADDR_W'(1);
            end
         end

         LS_DRAIN: begin
            if (accept && in_last) begin
               state_nxt     = LS_ERR;
               err_nxt       = 1'b1;
               core_hold_nxt = 1'b1;
            end
         end

         LS_DONE, LS_ERR: begin
            if (start) begin
               state_nxt      = LS_LOAD;
               word_count_nxt = '0;
               checksum_nxt   = '0;
               done_nxt       = 1'b0;
               err_nxt        = 1'b0;
               core_hold_nxt  = 1'b1;
            end
         end

         default: begin
            state_nxt = LS_IDLE;
         end
      endcase
   end

   // State and output registers; reset releases nothing to the core
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LS_IDLE;
         pad_addr   <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_hold  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
         checksum   <= '0;
      end else begin
         state      <= state_nxt;
         pad_addr   <= pad_addr_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         core_hold  <= core_hold_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         word_count <= word_count_nxt;
         checksum   <= checksum_nxt;
      end
   end

   // Expose the sequencer state for debug and checkers
   always_comb begin
      dbg_state = state;
   end

endmodule
